dcache_axi_refill: RTL and testbench
====================================

Name: dcache_axi_refill

Overview:
- Miss-handling engine directly downstream of the data cache.
- Consumes the cache's miss, write-back and address outputs and the victim line.
- Writes a dirty victim to memory as one AXI4 INCR burst, then fetches the missing line as one AXI4 INCR burst.
- Returns the fetched line with a one-cycle refresh pulse, which the cache uses to fill the way and release its stall.

Parameters:
CACHELINE_WD, 512, line width in bits; must be a multiple of 32; BEATS = CACHELINE_WD/32 (16 by default)
OFFSET_WD, 6, byte-offset bits in a line; equals log2(CACHELINE_WD/8)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
dcache_miss  input  1  cache requests a line fill; held high until refresh is accepted
dcache_raddr  input  32  address of the missing line
dcache_write_back  input  1  victim is dirty; qualified by dcache_miss
dcache_waddr  input  32  victim line address
dcache_cacheline_old  input  CACHELINE_WD  victim line data
dcache_refresh  output  1  one-cycle pulse: dcache_cacheline_new is valid
dcache_cacheline_new  output  CACHELINE_WD  assembled refill line
araddr  output  32  AXI read address
arlen  output  8  constant BEATS-1
arsize  output  3  constant 3'b010
arburst  output  2  constant 2'b01 (INCR)
arvalid  output  1  read-address valid
arready  input  1  read-address ready
rdata  input  32  read data
rlast  input  1  last read beat
rvalid  input  1  read-data valid
rready  output  1  read-data ready
awaddr  output  32  AXI write address
awlen  output  8  constant BEATS-1
awsize  output  3  constant 3'b010
awburst  output  2  constant 2'b01 (INCR)
awvalid  output  1  write-address valid
awready  input  1  write-address ready
wdata  output  32  write data
wstrb  output  4  constant 4'hF
wlast  output  1  last write beat
wvalid  output  1  write-data valid
wready  input  1  write-data ready
bvalid  input  1  write response valid
bready  output  1  write response ready

Behaviour:
- States: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, REFILL, HOLD.
- Reset (async, active-low): state IDLE. All valid/ready outputs, wlast and dcache_refresh are 0. Beat counter is 0. Latched addresses and line buffers are 0.
- A reset in any state aborts the transaction immediately. No completion of an in-flight burst is attempted.
- Transaction start, in IDLE with dcache_miss=1:
  - Latch {dcache_raddr[31:OFFSET_WD], 0}.
  - If dcache_write_back=1: also latch {dcache_waddr[31:OFFSET_WD], 0} and dcache_cacheline_old, then go to WB_AW.
  - Otherwise go to RD_AR.
- Low offset bits are always forced to 0 on araddr/awaddr.
- WB_AW: awvalid=1 with awaddr stable. On awvalid&&awready go to WB_W and clear the beat counter.
- WB_W:
  - wvalid=1; wdata = old_line[32*cnt +: 32].
  - wlast=1 when cnt==BEATS-1.
  - On wvalid&&wready, increment cnt; on the last beat go to WB_B.
  - wvalid is never dropped mid-burst; data is held stable while wready=0.
- WB_B: bready=1. On bvalid go to RD_AR. bresp is not examined.
- Write-before-read ordering is fixed. The refill never starts before the write response arrives.
- RD_AR: arvalid=1 with araddr stable. On arvalid&&arready go to RD_R and clear cnt.
- RD_R:
  - rready=1.
  - On rvalid, store rdata into new_line[32*cnt +: 32] and increment cnt.
  - Go to REFILL on the beat where cnt==BEATS-1. rlast is ignored for counting.
- REFILL: dcache_refresh=1 for exactly one cycle; dcache_cacheline_new holds the complete line. Then go to HOLD.
- HOLD: one cycle ignoring dcache_miss, which is still high while the cache updates its tag. Then go to IDLE.
- Outside REFILL, dcache_refresh=0. dcache_cacheline_new keeps its last value.
- Latency, zero-wait slave, clean miss: arvalid rises 1 cycle after miss; refresh 2+BEATS cycles after miss.
- dcache_miss deasserting mid-transaction is ignored; the transaction always completes.
- AW and W are serialized: W begins only after the AW handshake.

Optional Feature:
- Macro DCACHE_AXI_PERF_CNT_EN. When defined, two extra output ports are added:
  - perf_miss_cnt[31:0]: increments on every REFILL cycle.
  - perf_wb_cnt[31:0]: increments on every WB_B exit.
- Both counters are 0 on reset and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Clean miss, raddr=0x1C00_0044, arready=1, rdata=beat index 0..15 → araddr=0x1C00_0040, arlen=15; one refresh pulse; line word i == i; no AW activity.
- Dirty miss, waddr=0x0000_1000, old line word i=0xA000_0000+i, raddr=0x0000_2000 → AW 0x1000 precedes AR 0x2000; wdata sequence 0xA000_0000..0xA000_000F; wlast only on the 16th beat; AR only after bvalid.
- Backpressure: wready toggling 1/0 and rvalid gaps every other cycle → no beat lost or duplicated; wdata stable while wready=0; refresh after exactly 16 accepted read beats.
- Late handshakes: arready/awready held low 5 cycles → valid held high with stable address; state advances only on the handshake cycle.
- Reset asserted at read beat 7 → all valids/readies and refresh drop to 0 asynchronously; after release a fresh miss completes normally.
- With DCACHE_AXI_PERF_CNT_EN: 3 clean misses plus 2 dirty misses → perf_miss_cnt=5, perf_wb_cnt=2.

Source files
------------

// File: rtl/dcache_axi_refill.sv
// Data-cache miss engine: optional dirty-victim write-back burst, then line refill burst over AXI4.
// Define DCACHE_AXI_PERF_CNT_EN to add the perf_miss_cnt / perf_wb_cnt counter ports.
module dcache_axi_refill #(
    parameter int CACHELINE_WD = 512,
    parameter int OFFSET_WD    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dcache_miss,
    input  logic [31:0]             dcache_raddr,
    input  logic                    dcache_write_back,
    input  logic [31:0]             dcache_waddr,
    input  logic [CACHELINE_WD-1:0] dcache_cacheline_old,
    output logic                    dcache_refresh,
    output logic [CACHELINE_WD-1:0] dcache_cacheline_new,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready
`ifdef DCACHE_AXI_PERF_CNT_EN
    ,
    output logic [31:0]             perf_miss_cnt,
    output logic [31:0]             perf_wb_cnt
`endif
);

    localparam int BEATS  = CACHELINE_WD / 32;
    localparam int CNT_WD = $clog2(BEATS);
    localparam logic [CNT_WD-1:0] LAST_BEAT = CNT_WD'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_AW,
        WB_W,
        WB_B,
        RD_AR,
        RD_R,
        REFILL,
        HOLD
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_WD-1:0]       cnt;
    logic [31:0]             raddr_q;
    logic [31:0]             waddr_q;
    logic [CACHELINE_WD-1:0] old_line;
    logic [CACHELINE_WD-1:0] new_line;

    // Offset bits are dropped on purpose and rlast is redundant with the beat counter.
    logic unused_bits;
    assign unused_bits = ^{rlast, dcache_raddr[OFFSET_WD-1:0], dcache_waddr[OFFSET_WD-1:0]};

    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign awlen   = 8'(BEATS - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wstrb   = 4'hF;

    assign araddr               = raddr_q;
    assign awaddr               = waddr_q;
    assign wdata                = old_line[32*cnt +: 32];
    assign dcache_cacheline_new = new_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        awvalid        = 1'b0;
        wvalid         = 1'b0;
        wlast          = 1'b0;
        bready         = 1'b0;
        arvalid        = 1'b0;
        rready         = 1'b0;
        dcache_refresh = 1'b0;
        case (state)
            IDLE: begin
                if (dcache_miss) begin
                    state_next = dcache_write_back ? WB_AW : RD_AR;
                end
            end
            WB_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_next = WB_W;
                end
            end
            WB_W: begin
                wvalid = 1'b1;
                wlast  = (cnt == LAST_BEAT);
                if (wready && cnt == LAST_BEAT) begin
                    state_next = WB_B;
                end
            end
            WB_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid && cnt == LAST_BEAT) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                dcache_refresh = 1'b1;
                state_next     = HOLD;
            end
            // The cache still holds miss high here while it rewrites its tag.
            HOLD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            old_line <= '0;
            new_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dcache_miss) begin
                        raddr_q <= {dcache_raddr[31:OFFSET_WD], {OFFSET_WD{1'b0}}};
                        if (dcache_write_back) begin
                            waddr_q  <= {dcache_waddr[31:OFFSET_WD], {OFFSET_WD{1'b0}}};
                            old_line <= dcache_cacheline_old;
                        end
                    end
                end
                WB_AW: begin
                    if (awready) begin
                        cnt <= '0;
                    end
                end
                WB_W: begin
                    if (wready) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        cnt <= '0;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        new_line[32*cnt +: 32] <= rdata;
                        cnt                    <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DCACHE_AXI_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_miss_cnt <= '0;
            perf_wb_cnt   <= '0;
        end else begin
            if (state == REFILL) begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
            if (state == WB_B && bvalid) begin
                perf_wb_cnt <= perf_wb_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_axi_refill.sv
// Randomized bench for dcache_axi_refill: AXI slave model with backpressure, line scoreboard and latency checks.
module tb_dcache_axi_refill;

    localparam int LINE_WD = 512;
    localparam int BEATS   = LINE_WD / 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               dcache_miss;
    logic [31:0]        dcache_raddr;
    logic               dcache_write_back;
    logic [31:0]        dcache_waddr;
    logic [LINE_WD-1:0] dcache_cacheline_old;
    logic               dcache_refresh;
    logic [LINE_WD-1:0] dcache_cacheline_new;
    logic [31:0]        araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;
    logic [31:0]        rdata;
    logic               rlast;
    logic               rvalid;
    logic               rready;
    logic [31:0]        awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               awvalid;
    logic               awready;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    logic               bvalid;
    logic               bready;
`ifdef DCACHE_AXI_PERF_CNT_EN
    logic [31:0]        perf_miss_cnt;
    logic [31:0]        perf_wb_cnt;
`endif

    always #5 clk = ~clk;

    dcache_axi_refill #(.CACHELINE_WD(LINE_WD), .OFFSET_WD(6)) dut (
        .clk(clk), .reset(reset),
        .dcache_miss(dcache_miss), .dcache_raddr(dcache_raddr),
        .dcache_write_back(dcache_write_back), .dcache_waddr(dcache_waddr),
        .dcache_cacheline_old(dcache_cacheline_old),
        .dcache_refresh(dcache_refresh), .dcache_cacheline_new(dcache_cacheline_new),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
`ifdef DCACHE_AXI_PERF_CNT_EN
        ,
        .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0]        old_words[BEATS];
    logic [LINE_WD-1:0] exp_line;
    logic [31:0]        exp_raddr, exp_waddr;
    logic [31:0]        aw_last, ar_last, w_prev;
    bit                 exp_dirty, rnd_data, b_done, aw_pend, ar_pend, w_stall, w_tog, r_tog;
    int                 bp_mode, aw_wait, ar_wait, b_wait;
    int                 aw_cnt, ar_cnt, w_beats, r_beats, refresh_cnt;
    int                 miss_cyc, first_ar_cyc, refresh_cyc;
    int                 exp_miss_perf = 0;
    int                 exp_wb_perf   = 0;

    task automatic checkOutput(input string tag, input logic [LINE_WD-1:0] obs,
                               input logic [LINE_WD-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clearModel();
        aw_cnt = 0; ar_cnt = 0; w_beats = 0; r_beats = 0; refresh_cnt = 0;
        b_wait = 0; b_done = 0; aw_pend = 0; ar_pend = 0; w_stall = 0;
        w_tog = 1; r_tog = 1; aw_wait = 0; ar_wait = 0;
        first_ar_cyc = -1; refresh_cyc = -1; exp_line = '0;
    endtask

    // AXI slave plus protocol/ordering monitor, evaluated mid-cycle.
    // Sections run R, AR, B, W, AW so each ordering check only sees earlier handshakes.
    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                clearModel();
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = 0;
            end else begin
                if (rready) checkOutput("r_after_ar", ar_cnt, 1);
                rvalid = 0;
                rlast  = 0;
                if (ar_cnt == 1 && r_beats < BEATS) begin
                    checkOutput("rready_in_burst", rready, 1);
                    case (bp_mode)
                        0:       rvalid = 1;
                        1:       rvalid = r_tog;
                        default: rvalid = 1'($urandom_range(0, 1));
                    endcase
                    r_tog = ~r_tog;
                    if (rvalid) begin
                        rdata = rnd_data ? $urandom : 32'(r_beats);
                        rlast = (r_beats == BEATS - 1);
                        exp_line[32*r_beats +: 32] = rdata;
                        r_beats++;
                    end
                end

                arready = 0;
                if (arvalid) begin
                    if (ar_pend) checkOutput("araddr_stable", araddr, ar_last);
                    if (first_ar_cyc < 0) first_ar_cyc = cyc;
                    ar_pend = 1;
                    ar_last = araddr;
                    if (ar_wait > 0) ar_wait--;
                    else begin
                        arready = 1;
                        ar_pend = 0;
                        ar_cnt++;
                        checkOutput("araddr", araddr, exp_raddr);
                        checkOutput("ar_after_b", b_done, exp_dirty);
                    end
                end else if (ar_pend) checkOutput("arvalid_held", arvalid, 1);

                bvalid = 0;
                if (w_beats == BEATS && !b_done) begin
                    if (b_wait > 0) b_wait--;
                    else begin
                        bvalid = 1;
                        if (bready) b_done = 1;
                    end
                end

                wready = 0;
                if (wvalid) begin
                    checkOutput("w_after_aw", aw_cnt, 1);
                    if (w_beats >= BEATS) checkOutput("w_beat_count", w_beats, BEATS - 1);
                    else begin
                        if (w_stall) checkOutput("wdata_stable", wdata, w_prev);
                        case (bp_mode)
                            0:       wready = 1;
                            1:       wready = w_tog;
                            default: wready = 1'($urandom_range(0, 1));
                        endcase
                        w_tog = ~w_tog;
                        if (wready) begin
                            checkOutput("wdata", wdata, old_words[w_beats]);
                            checkOutput("wlast", wlast, w_beats == BEATS - 1);
                            w_beats++;
                            w_stall = 0;
                            if (w_beats == BEATS) b_wait = $urandom_range(0, 3);
                        end else begin
                            w_stall = 1;
                            w_prev  = wdata;
                        end
                    end
                end else if (w_beats > 0 && w_beats < BEATS) checkOutput("wvalid_held", wvalid, 1);

                awready = 0;
                if (awvalid) begin
                    if (aw_pend) checkOutput("awaddr_stable", awaddr, aw_last);
                    aw_pend = 1;
                    aw_last = awaddr;
                    if (aw_wait > 0) aw_wait--;
                    else begin
                        awready = 1;
                        aw_pend = 0;
                        aw_cnt++;
                        checkOutput("awaddr", awaddr, exp_waddr);
                        checkOutput("aw_before_ar", ar_cnt, 0);
                    end
                end else if (aw_pend) checkOutput("awvalid_held", awvalid, 1);

                if (dcache_refresh) begin
                    refresh_cnt++;
                    refresh_cyc = cyc;
                    checkOutput("refresh_beats", r_beats, BEATS);
                    checkOutput("line", dcache_cacheline_new, exp_line);
                end
            end
        end
    end

    task automatic startMiss(input bit dirty, input logic [31:0] raddr, input logic [31:0] waddr,
                             input int bp, input int aw_w, input int ar_w, input bit rnd);
        logic [LINE_WD-1:0] old_line;
        @(negedge clk); #1;
        clearModel();
        exp_dirty = dirty; bp_mode = bp; aw_wait = aw_w; ar_wait = ar_w; rnd_data = rnd;
        exp_raddr = {raddr[31:6], 6'b0};
        exp_waddr = {waddr[31:6], 6'b0};
        for (int i = 0; i < BEATS; i++) begin
            old_words[i] = rnd ? $urandom : 32'hA000_0000 + 32'(i);
            old_line[32*i +: 32] = old_words[i];
        end
        dcache_miss = 1; dcache_write_back = dirty; dcache_raddr = raddr;
        dcache_waddr = waddr; dcache_cacheline_old = old_line;
        miss_cyc = cyc;
        @(negedge clk); #1;
        dcache_raddr = $urandom; dcache_waddr = $urandom;
        dcache_cacheline_old = {BEATS{$urandom}};
        dcache_write_back = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input bit dirty, input logic [31:0] raddr, input logic [31:0] waddr,
                                 input int bp, input int aw_w, input int ar_w, input bit rnd,
                                 input bit check_lat);
        int t;
        startMiss(dirty, raddr, waddr, bp, aw_w, ar_w, rnd);
        t = 0;
        while (refresh_cnt == 0 && t < 1000) begin
            @(negedge clk); #1;
            t++;
        end
        checkOutput("refresh_seen", refresh_cnt, 1);
        // Miss stays high through the cycle after the refresh to exercise HOLD.
        repeat (2) @(negedge clk);
        #1;
        dcache_miss = 0;
        dcache_write_back = 0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("refresh_pulses", refresh_cnt, 1);
        checkOutput("aw_count", aw_cnt, dirty ? 1 : 0);
        checkOutput("w_count", w_beats, dirty ? BEATS : 0);
        checkOutput("b_done", b_done, dirty);
        checkOutput("ar_count", ar_cnt, 1);
        checkOutput("r_count", r_beats, BEATS);
        checkOutput("line_kept", dcache_cacheline_new, exp_line);
        if (check_lat) begin
            checkOutput("lat_arvalid", first_ar_cyc - miss_cyc, 1);
            checkOutput("lat_refresh", refresh_cyc - miss_cyc, 2 + BEATS);
        end
        exp_miss_perf++;
        if (dirty) exp_wb_perf++;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ctrl"}, {arvalid, awvalid, wvalid, rready, bready, wlast, dcache_refresh}, 7'b0);
        checkOutput({tag, "_line"}, dcache_cacheline_new, '0);
        checkOutput({tag, "_araddr"}, araddr, 32'h0);
        checkOutput({tag, "_awaddr"}, awaddr, 32'h0);
`ifdef DCACHE_AXI_PERF_CNT_EN
        checkOutput({tag, "_perf"}, {perf_miss_cnt, perf_wb_cnt}, 64'h0);
`endif
    endtask

    initial begin
        reset = 0; dcache_miss = 0; dcache_write_back = 0;
        dcache_raddr = 0; dcache_waddr = 0; dcache_cacheline_old = '0;
        #3;
        checkResetState("reset");
        checkOutput("arlen", arlen, 8'd15);
        checkOutput("arsize", arsize, 3'b010);
        checkOutput("arburst", arburst, 2'b01);
        checkOutput("awlen", awlen, 8'd15);
        checkOutput("awsize", awsize, 3'b010);
        checkOutput("awburst", awburst, 2'b01);
        checkOutput("wstrb", wstrb, 4'hF);
        repeat (2) @(negedge clk);
        #1 reset = 1;

        $display("[TB] clean miss, zero-wait slave");
        applyStimulus(0, 32'h1C00_0044, 32'h0, 0, 0, 0, 0, 1);
        $display("[TB] dirty miss, fixed victim pattern");
        applyStimulus(1, 32'h0000_2000, 32'h0000_1000, 0, 0, 0, 0, 0);
        $display("[TB] dirty miss, toggling backpressure");
        applyStimulus(1, $urandom, $urandom, 1, 0, 0, 1, 0);
        $display("[TB] late AW/AR handshakes");
        applyStimulus(1, $urandom, $urandom, 0, 5, 5, 1, 0);
        applyStimulus(0, $urandom, $urandom, 1, 0, 5, 1, 0);
        $display("[TB] randomized misses");
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 2,
                          $urandom_range(0, 3), $urandom_range(0, 3), 1, 0);
        end

        $display("[TB] reset during read burst");
        begin
            int t;
            startMiss(0, $urandom, $urandom, 0, 0, 0, 1);
            t = 0;
            while (r_beats < 7 && t < 200) begin
                @(negedge clk); #1;
                t++;
            end
            checkOutput("reached_beat7", r_beats, 7);
            #2 reset = 0;
            #1;
            checkResetState("async_reset");
            dcache_miss = 0;
            dcache_write_back = 0;
            exp_miss_perf = 0;
            exp_wb_perf = 0;
            repeat (2) @(negedge clk);
            #1 reset = 1;
        end
        applyStimulus(0, $urandom, $urandom, 0, 0, 0, 1, 1);
        applyStimulus(0, $urandom, $urandom, 2, 1, 2, 1, 0);
        applyStimulus(0, $urandom, $urandom, 1, 0, 0, 1, 0);
        applyStimulus(1, $urandom, $urandom, 2, 2, 1, 1, 0);
        applyStimulus(1, $urandom, $urandom, 1, 0, 3, 1, 0);
`ifdef DCACHE_AXI_PERF_CNT_EN
        checkOutput("perf_miss_cnt", perf_miss_cnt, exp_miss_perf);
        checkOutput("perf_wb_cnt", perf_wb_cnt, exp_wb_perf);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
